gpio_pin_ctrl: RTL
==================

# gpio_pin_ctrl

Pad-side GPIO stage that sits directly downstream of the memory-mapped GPIO register block. It consumes the tristate, data and interrupt-mask registers to drive the pads. It returns the synchronized, debounced pin state as `ro_gpio_pinstate`. It also detects per-pin edges and latches them into sticky interrupt-pending bits, which raise a single `irq` to the core.

## Interface
Parameters:
- `WIDTH`, 16, number of GPIO pins.
- `DB_CYCLES`, 4, consecutive cycles a synchronized input must differ from the stable value before it is accepted; legal range 1..255.

Ports:
- `clk`  in  1  master clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rf_gpio_tristate`  in  WIDTH  1 = pin is an input (pad driver off), 0 = pin is driven.
- `rf_gpio_datareg`  in  WIDTH  value driven on output pins.
- `rf_gpio_interrupt_mask`  in  WIDTH  1 = edge events on this pin set its pending bit.
- `irq_clear`  in  WIDTH  single-cycle write-1-to-clear pulses for pending bits.
- `gpio_pad_in`  in  WIDTH  raw asynchronous pad inputs.
- `gpio_pad_out`  out  WIDTH  pad output data.
- `gpio_pad_oe`  out  WIDTH  pad output enable, active high.
- `ro_gpio_pinstate`  out  WIDTH  debounced pin state, fed back to the register block.
- `irq_pending`  out  WIDTH  sticky per-pin pending bits.
- `irq`  out  1  registered OR of `irq_pending & rf_gpio_interrupt_mask`.

## Operation
- **Reset values.**
  - While `reset`=0, all of the following are 0: all outputs, synchronizer flops, stable values, debounce counters and pending bits.
- **Output path.**
  - `gpio_pad_oe <= ~rf_gpio_tristate` and `gpio_pad_out <= rf_gpio_datareg` are registered.
  - Output path latency is 1 cycle.
- **Input path, per pin.**
  - A 2-flop synchronizer `sync1 -> sync2` feeds a debouncer holding `stable` and a counter `cnt`.
  - Each edge with `sync2 != stable`: if `cnt == DB_CYCLES-1`, then `stable <= sync2` and `cnt <= 0`; otherwise `cnt++`.
  - Each edge with `sync2 == stable`: `cnt <= 0`. A glitch shorter than `DB_CYCLES` cycles therefore never reaches `stable`.
  - `ro_gpio_pinstate = stable`.
  - The counter width is `$clog2(DB_CYCLES+1)`. It never wraps, because it saturates by resetting at acceptance.
- **Edge events.**
  - An event is the cycle in which `stable` updates. Both rising and falling edges count.
- **Pending.**
  - Priority per pin, highest first:
    1. event & `rf_gpio_interrupt_mask`: set `irq_pending`.
    2. else `irq_clear`: clear `irq_pending`.
    3. else hold.
  - Simultaneous event and clear leaves the bit set (set wins).
  - Mask is sampled at event time. Clearing a mask bit does not clear pending; it only removes that bit from `irq`.
  - Output pins (tristate=0) still sample the pad and may raise events through loopback.
- **irq.**
  - `irq <= |(irq_pending & rf_gpio_interrupt_mask)`.
- **Reset mid-operation.**
  - Immediately clears everything: counting in progress and pending bits are lost.
  - After reset release, a pad held high is accepted after the normal latency and produces an event. That event is masked because the register block resets the mask to 0.

## Timing
- Pad change settles before edge 1: `sync2` updates at edge 2, `stable` and `ro_gpio_pinstate` at edge 2+`DB_CYCLES`.
- `irq_pending` is set at that same edge; `irq` rises one edge later.
- With the defaults, pinstate and pending update at edge 6 and `irq` at edge 7.
- `irq_clear` at edge n: pending drops at edge n, and `irq` drops at n+1 unless other masked bits are pending.
- `rf_gpio_*` change at edge n: pads update at edge n+1.

## Structure
- Package `gpio_pkg`: `GPIO_WIDTH`=16 and `GPIO_DB_CYCLES_DEF`=4.
- Sub-module `gpio_debounce`: one pin's synchronizer, counter, stable flop and event pulse.
  - Instantiated `WIDTH` times in a generate loop.
  - Pending and irq logic stay in the top.

## Test plan
- **Reset then drive outputs.** Release reset, set tristate=16'hFF00 and datareg=16'h00A5. Required: oe=16'h00FF and pad_out=16'h00A5 one cycle later; irq=0.
- **Clean rising edge.** Set mask=16'h0001, raise pad bit 0 and hold. Required: pinstate[0]=1 and pending[0]=1 at edge 6; irq=1 at edge 7.
- **Glitch rejection.** Pulse pad bit 3 high for 3 cycles with DB_CYCLES=4. Required: pinstate, pending and irq stay 0.
- **Clear and set collision.** Pulse `irq_clear[0]` on the same edge as a new masked falling-edge event on pin 0. Required: pending[0] remains 1. A later clear alone drops pending[0] and then irq on the next cycle.
- **Masked event.** Set mask=0 and toggle pin 5. Required: pinstate[5] follows the pin and pending stays 0. Then set pending with mask=1 and clear the mask. Required: pending stays 1 and irq drops one cycle later.
- **Async reset mid-count.** Assert reset 2 cycles into a debounce of pin 7. Required: all outputs are 0 immediately without a clock edge, and no event occurs after release if the pad has returned low.

Source files
------------

// File: rtl/gpio_pkg.sv
//------------------------------------------------------------------------------
// gpio_pkg: shared sizing constants for the GPIO pad-side stage.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpio_pkg;
  localparam int GPIO_WIDTH         = 16;
  localparam int GPIO_DB_CYCLES_DEF = 4;
endpackage

`default_nettype wire

// File: rtl/gpio_debounce.sv
//------------------------------------------------------------------------------
// gpio_debounce: one pin's 2-flop synchronizer, debounce counter, stable flop
// and single-cycle event pulse on acceptance. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pad,
  output logic o_stable,
  output logic o_event
);

  localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_differ;
  logic               w_accept;

  assign w_differ = (r_sync2 != r_stable);
  // Acceptance restarts the counter, so it never runs past c_CNT_LAST.
  assign w_accept = w_differ && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
      if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_event  = w_accept;

endmodule

`default_nettype wire

// File: rtl/gpio_pin_ctrl.sv
//------------------------------------------------------------------------------
// gpio_pin_ctrl: registered pad drivers, per-pin debounced inputs, sticky edge
// pending bits and a single registered interrupt line. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_pin_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_WIDTH,
  parameter int DB_CYCLES = GPIO_DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rf_gpio_tristate,
  input  logic [WIDTH-1:0] rf_gpio_datareg,
  input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  input  logic [WIDTH-1:0] irq_clear,
  input  logic [WIDTH-1:0] gpio_pad_in,
  output logic [WIDTH-1:0] gpio_pad_out,
  output logic [WIDTH-1:0] gpio_pad_oe,
  output logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_event;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
      gpio_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_db (
        .clk      (clk),
        .reset    (reset),
        .i_pad    (gpio_pad_in[g]),
        .o_stable (w_stable[g]),
        .o_event  (w_event[g])
      );
    end
  endgenerate

  assign ro_gpio_pinstate = w_stable;

  // A masked event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_pad_oe  <= '0;
      gpio_pad_out <= '0;
      irq_pending  <= '0;
      irq          <= 1'b0;
    end else begin
      gpio_pad_oe  <= ~rf_gpio_tristate;
      gpio_pad_out <= rf_gpio_datareg;
      irq_pending  <= (w_event & rf_gpio_interrupt_mask) | (irq_pending & ~irq_clear);
      irq          <= |(irq_pending & rf_gpio_interrupt_mask);
    end
  end

endmodule

`default_nettype wire
